// File: rtl/rxe_lencheck_pkg.sv
// rtl/rxe_lencheck_pkg.sv - shared constants and event decode for the RX frame length checker
package rxe_lencheck_pkg;

    localparam int ETH_MINBYTES = 60;
    localparam int ETH_MAXBYTES = 1518;
    localparam int ETH_MAXJUMBO = 9018;

    typedef enum logic [1:0] {
        EV_IDLE  = 2'd0,
        EV_START = 2'd1,
        EV_BYTE  = 2'd2,
        EV_END   = 2'd3
    } rx_event_e;

    // A frame is a contiguous run of valid bytes; the edge of valid against its
    // previous value tells which part of the frame this byte-clock belongs to.
    function automatic rx_event_e classify_event(input logic v, input logic last_v);
        case ({v, last_v})
            2'b10:   return EV_START;
            2'b11:   return EV_BYTE;
            2'b01:   return EV_END;
            default: return EV_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rxe_satcnt.sv
// rtl/rxe_satcnt.sv - saturating statistics up-counter with synchronous clear
module rxe_satcnt #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Clear takes priority so a clear landing on an increment leaves zero.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rxe_lencheck.sv
// rtl/rxe_lencheck.sv - RX frame length checker: runt/giant flags, frame length and statistics
module rxe_lencheck
    import rxe_lencheck_pkg::*;
#(
    parameter int MINBYTES = ETH_MINBYTES,
    parameter int MAXBYTES = ETH_MAXBYTES,
    parameter int LGLEN    = 11,
    parameter int LGSTAT   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ce,
    input  logic              i_v,
    input  logic              i_min_en,
    input  logic              i_max_en,
    input  logic              i_clr_stats,
    output logic [LGLEN-1:0]  o_len,
    output logic              o_done,
    output logic              o_runt,
    output logic              o_giant,
    output logic              o_err,
    output logic [LGSTAT-1:0] o_nrunt,
    output logic [LGSTAT-1:0] o_ngiant
);

    localparam logic [LGLEN-1:0] MIN_L = LGLEN'(MINBYTES);
    localparam logic [LGLEN-1:0] MAX_L = LGLEN'(MAXBYTES);

    logic             r_last_v;
    logic [LGLEN-1:0] r_len;
    logic [LGLEN-1:0] r_len_out;
    logic             r_en_min;
    logic             r_en_max;
    logic             r_done;
    logic             r_runt;
    logic             r_giant;
    logic             r_err;

    rx_event_e        w_event;
    logic             w_ev_start;
    logic             w_ev_byte;
    logic             w_ev_end;
    logic             w_ev_idle;
    logic             w_runt_next;
    logic             w_nrunt_inc;
    logic             w_ngiant_inc;

    assign w_event      = classify_event(i_v, r_last_v);
    assign w_ev_start   = i_ce && (w_event == EV_START);
    assign w_ev_byte    = i_ce && (w_event == EV_BYTE);
    assign w_ev_end     = i_ce && (w_event == EV_END);
    assign w_ev_idle    = i_ce && (w_event == EV_IDLE);
    assign w_runt_next  = r_en_min && (r_len < MIN_L);
    assign w_nrunt_inc  = w_ev_end && w_runt_next;
    assign w_ngiant_inc = w_ev_end && r_giant;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last_v <= 1'b0;
        end else if (i_ce) begin
            r_last_v <= i_v;
        end
    end

    // Running byte count; sticks at all-ones on oversize frames instead of wrapping.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_len <= '0;
        end else if (w_ev_start) begin
            r_len <= LGLEN'(1);
        end else if (w_ev_byte) begin
            if (r_len != '1) begin
                r_len <= r_len + LGLEN'(1);
            end
        end else if (w_ev_end) begin
            r_len <= '0;
        end
    end

    // Enables are sampled once per frame so mid-frame changes cannot split a verdict.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_en_min <= 1'b0;
            r_en_max <= 1'b0;
        end else if (w_ev_start) begin
            r_en_min <= i_min_en;
            r_en_max <= i_max_en;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_len_out <= '0;
        end else if (w_ev_end) begin
            r_len_out <= r_len;
        end
    end

    // Giant rises as soon as the oversize byte arrives so downstream can abort early.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_done  <= 1'b0;
            r_runt  <= 1'b0;
            r_giant <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_ev_start || w_ev_idle) begin
            r_done  <= 1'b0;
            r_runt  <= 1'b0;
            r_giant <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_ev_byte) begin
            if (r_en_max && (r_len == MAX_L)) begin
                r_giant <= 1'b1;
            end
        end else if (w_ev_end) begin
            r_done <= 1'b1;
            r_runt <= w_runt_next;
            r_err  <= w_runt_next || r_giant;
        end
    end

    rxe_satcnt #(
        .WIDTH (LGSTAT)
    ) u_nrunt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (w_nrunt_inc),
        .i_clr     (i_clr_stats),
        .o_cnt     (o_nrunt)
    );

    rxe_satcnt #(
        .WIDTH (LGSTAT)
    ) u_ngiant (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (w_ngiant_inc),
        .i_clr     (i_clr_stats),
        .o_cnt     (o_ngiant)
    );

    assign o_len   = r_len_out;
    assign o_done  = r_done;
    assign o_runt  = r_runt;
    assign o_giant = r_giant;
    assign o_err   = r_err;

endmodule
